ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Two-requester arbiter in front of the RAM bridge master port. Requester 0 is instruction fetch; requester 1 is load/store. Requester 1 has fixed priority; a starvation counter bounds how long requester 0 can be locked out. The block grants one requester per cycle, forwards its access to the bridge, and returns read data to the owning requester one cycle later.

Parameters:
BUS_WIDTH, 32, address width
DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits
STARVE_MAX, 4, consecutive denied cycles before requester 0 is force-granted; legal range >= 1

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
r0_ren  in  1  requester 0 read request
r0_wen  in  DATA_WIDTH/8  requester 0 byte write enables
r0_raddr  in  BUS_WIDTH  requester 0 read address
r0_waddr  in  BUS_WIDTH  requester 0 write address
r0_wdata  in  DATA_WIDTH  requester 0 write data
r0_gnt  out  1  requester 0 access accepted this cycle
r0_rvalid  out  1  requester 0 read data valid
r0_rdata  out  DATA_WIDTH  requester 0 read data
r1_*  same set as r0_*, for requester 1
m_ren  out  1  to bridge
m_wen  out  DATA_WIDTH/8  to bridge
m_raddr  out  BUS_WIDTH  to bridge
m_waddr  out  BUS_WIDTH  to bridge
m_wdata  out  DATA_WIDTH  to bridge
m_rdata  in  DATA_WIDTH  from bridge; valid the cycle after m_ren

Behaviour:
- Request detection: reqN = rN_ren | (|rN_wen).
- Grant is combinational, in the same cycle as the request. At most one of r0_gnt and r1_gnt is high.
- Grant rules:
  - Only one requester active: grant it.
  - Both active: grant r1, unless starve_cnt == STARVE_MAX, in which case grant r0.
- Starvation counter (starve_cnt, width $clog2(STARVE_MAX+1)):
  - Increments when req0 & ~r0_gnt.
  - Clears when r0_gnt or ~req0.
  - Saturates at STARVE_MAX.
- Forwarding:
  - The granted requester's ren, wen, raddr, waddr and wdata drive the m_* outputs.
  - With no grant: m_ren = 0, m_wen = 0, addresses and wdata = 0.
  - A requester may issue a read and a write in the same cycle; both are forwarded.
- Requester contract: hold all request signals stable until gnt is seen. The ungranted requester's signals are ignored. A new request may be presented in the cycle after gnt.
- Read response tracking:
  - Registered flags rd_pend and rd_owner are set from (m_ren, granted id) at each clock edge.
  - In cycle T+1 after a granted read in cycle T, rX_rvalid = 1 for the owner and rX_rdata = m_rdata.
  - The non-owner's rvalid = 0 and rdata = 0.
- Back-to-back reads pipeline with one response per cycle, no bubbles. Alternating owners are tracked per cycle.
- Writes complete in the grant cycle; there is no write response.
- Reset values:
  - starve_cnt = 0, rd_pend = 0, rd_owner = 0.
  - All rvalid = 0. All rdata = 0.
  - gnt and m_* follow the combinational rules, so they are 0 with no requests.
- Reset mid-operation: a read granted in the cycle reset asserts produces no rvalid. The first cycle after reset deasserts starts with a clean counter.
- Same-cycle conflict: r0 forced grant and r1 request arrive together. r1 is denied and holds its request; r1 is granted next cycle if still contending, since starve_cnt has cleared.

Decomposition:
- Shared package ram_arb_pkg:
  - Requester id localparams REQ_IF = 1'b0, REQ_LS = 1'b1.
  - Default STARVE_MAX.
- One natural sub-module: ram_arb_grant, holding the request detection, priority/starvation grant logic and starve_cnt. The top holds the muxing and read response tracking.

Test Plan:
- Single read: r0_ren = 1, r0_raddr = 0x0000_0100 -> r0_gnt = 1 same cycle, m_raddr = 0x100; next cycle r0_rvalid = 1, r0_rdata = m_rdata (0xDEAD_BEEF), r1_rvalid = 0.
- Contention priority: r0 and r1 both ren every cycle, STARVE_MAX = 4 -> r1 granted 4 cycles, r0 granted in the 5th; the pattern repeats every 5 cycles.
- Pipelined alternating reads: r1 read at cycle T, r0 read at T+1 (r1 idle) -> r1_rvalid at T+1, r0_rvalid at T+2, each with the correct m_rdata.
- Byte write: r1_wen = 4'b0011, r1_waddr = 0x0001_0004, r1_wdata = 0x1234_5678 -> m_wen = 4'b0011 and m_waddr/m_wdata match in the same cycle; no rvalid follows.
- Mixed access: r0 write and r1 read in the same cycle -> only r1 granted; r0 held and granted the next cycle with m_wen equal to r0_wen.
- Reset mid-read: assert reset in the cycle of a granted r0 read -> r0_rvalid stays 0; after release, starve_cnt = 0 and the first contention grants r1.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM bridge arbiter: requester ids and default sizing.
package ram_arb_pkg;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    localparam int unsigned BUS_WIDTH_DEFAULT  = 32;
    localparam int unsigned DATA_WIDTH_DEFAULT = 32;
    localparam int unsigned STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/ram_arb_grant.sv
// Request detection and fixed-priority grant, with a starvation counter that
// force-grants instruction fetch after STARVE_MAX consecutive denied cycles.
module ram_arb_grant
    import ram_arb_pkg::*;
#(
    parameter int unsigned BE_WIDTH   = DATA_WIDTH_DEFAULT / 8,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                r0_ren,
    input  logic [BE_WIDTH-1:0] r0_wen,
    input  logic                r1_ren,
    input  logic [BE_WIDTH-1:0] r1_wen,
    output logic                r0_gnt,
    output logic                r1_gnt
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             req0;
    logic             req1;
    logic             force0;

    // Load/store wins contention unless fetch has been denied long enough.
    always_comb begin
        req0   = r0_ren | (|r0_wen);
        req1   = r1_ren | (|r1_wen);
        force0 = (starve_cnt == CNT_W'(STARVE_MAX));
        r0_gnt = req0 & (~req1 | force0);
        r1_gnt = req1 & ~r0_gnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (~req0 | r0_gnt) begin
            starve_cnt <= '0;
        end else if (!force0) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of the RAM bridge: forwards the granted access
// and steers the next-cycle read data back to the requester that issued it.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = BUS_WIDTH_DEFAULT,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    r0_ren,
    input  logic [DATA_WIDTH/8-1:0] r0_wen,
    input  logic [BUS_WIDTH-1:0]    r0_raddr,
    input  logic [BUS_WIDTH-1:0]    r0_waddr,
    input  logic [DATA_WIDTH-1:0]   r0_wdata,
    output logic                    r0_gnt,
    output logic                    r0_rvalid,
    output logic [DATA_WIDTH-1:0]   r0_rdata,

    input  logic                    r1_ren,
    input  logic [DATA_WIDTH/8-1:0] r1_wen,
    input  logic [BUS_WIDTH-1:0]    r1_raddr,
    input  logic [BUS_WIDTH-1:0]    r1_waddr,
    input  logic [DATA_WIDTH-1:0]   r1_wdata,
    output logic                    r1_gnt,
    output logic                    r1_rvalid,
    output logic [DATA_WIDTH-1:0]   r1_rdata,

    output logic                    m_ren,
    output logic [DATA_WIDTH/8-1:0] m_wen,
    output logic [BUS_WIDTH-1:0]    m_raddr,
    output logic [BUS_WIDTH-1:0]    m_waddr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    input  logic [DATA_WIDTH-1:0]   m_rdata
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic rd_pend;
    logic rd_owner;

    ram_arb_grant #(
        .BE_WIDTH   (BE_WIDTH),
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .clk    (clk),
        .reset  (reset),
        .r0_ren (r0_ren),
        .r0_wen (r0_wen),
        .r1_ren (r1_ren),
        .r1_wen (r1_wen),
        .r0_gnt (r0_gnt),
        .r1_gnt (r1_gnt)
    );

    // Bridge-side mux; an idle bus is driven to all zeros.
    always_comb begin
        m_ren   = 1'b0;
        m_wen   = '0;
        m_raddr = '0;
        m_waddr = '0;
        m_wdata = '0;
        if (r1_gnt) begin
            m_ren   = r1_ren;
            m_wen   = r1_wen;
            m_raddr = r1_raddr;
            m_waddr = r1_waddr;
            m_wdata = r1_wdata;
        end else if (r0_gnt) begin
            m_ren   = r0_ren;
            m_wen   = r0_wen;
            m_raddr = r0_raddr;
            m_waddr = r0_waddr;
            m_wdata = r0_wdata;
        end
    end

    // One-deep read tracker; a new read may be issued every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            rd_owner <= REQ_IF;
        end else begin
            rd_pend  <= m_ren;
            rd_owner <= r1_gnt ? REQ_LS : REQ_IF;
        end
    end

    always_comb begin
        r0_rvalid = rd_pend & (rd_owner == REQ_IF);
        r1_rvalid = rd_pend & (rd_owner == REQ_LS);
        r0_rdata  = r0_rvalid ? m_rdata : '0;
        r1_rdata  = r1_rvalid ? m_rdata : '0;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized
// holding requesters checked against a behavioural arbitration model.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int unsigned BW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BE = DW / 8;
    localparam int unsigned SM = 4;
    localparam int unsigned MW = 1 + BE + BW + BW + DW;

    typedef struct {
        bit            act;
        logic          ren;
        logic [BE-1:0] wen;
        logic [BW-1:0] raddr;
        logic [BW-1:0] waddr;
        logic [DW-1:0] wdata;
    } rq_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          r0_ren, r1_ren, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, m_ren;
    logic [BE-1:0] r0_wen, r1_wen, m_wen;
    logic [BW-1:0] r0_raddr, r0_waddr, r1_raddr, r1_waddr, m_raddr, m_waddr;
    logic [DW-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, m_wdata, m_rdata;
    logic [MW-1:0] m_bus;

    ram_arbiter #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .r0_ren(r0_ren), .r0_wen(r0_wen), .r0_raddr(r0_raddr), .r0_waddr(r0_waddr),
        .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_ren(r1_ren), .r1_wen(r1_wen), .r1_raddr(r1_raddr), .r1_waddr(r1_waddr),
        .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .m_ren(m_ren), .m_wen(m_wen), .m_raddr(m_raddr), .m_waddr(m_waddr),
        .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    assign m_bus = {m_ren, m_wen, m_raddr, m_waddr, m_wdata};

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: consecutive cycles fetch has been refused, last-cycle read owner.
    int denied     = 0;
    bit pend       = 1'b0;
    bit pend_owner = 1'b0;

    function automatic rq_t no_rq();
        rq_t r;
        r.act = 1'b0; r.ren = 1'b0; r.wen = '0;
        r.raddr = '0; r.waddr = '0; r.wdata = '0;
        return r;
    endfunction

    function automatic rq_t mk(logic ren, logic [BE-1:0] wen, logic [BW-1:0] ra,
                               logic [BW-1:0] wa, logic [DW-1:0] wd);
        rq_t r;
        r.act = 1'b1; r.ren = ren; r.wen = wen;
        r.raddr = ra; r.waddr = wa; r.wdata = wd;
        return r;
    endfunction

    function automatic rq_t rand_rq();
        rq_t r;
        r.act   = 1'b1;
        r.ren   = 1'($urandom_range(0, 1));
        r.wen   = ($urandom_range(0, 1) == 1) ? BE'($urandom) : '0;
        if (!r.ren && r.wen == '0) r.ren = 1'b1;
        r.raddr = $urandom;
        r.waddr = $urandom;
        r.wdata = $urandom;
        return r;
    endfunction

    function automatic bit is_req(rq_t r);
        return r.act && (r.ren || (r.wen != '0));
    endfunction

    function automatic bit model_g0(rq_t a, rq_t b);
        return is_req(a) && (!is_req(b) || denied >= int'(SM));
    endfunction

    function automatic logic [MW-1:0] pack_rq(rq_t r);
        return {r.ren, r.wen, r.raddr, r.waddr, r.wdata};
    endfunction

    function automatic logic [MW-1:0] model_m(rq_t a, rq_t b);
        bit g0 = model_g0(a, b);
        bit g1 = is_req(b) && !g0;
        if (g0) return pack_rq(a);
        if (g1) return pack_rq(b);
        return '0;
    endfunction

    task automatic model_step(input rq_t a, input rq_t b);
        bit g0 = model_g0(a, b);
        bit g1 = is_req(b) && !g0;
        if (is_req(a) && !g0) denied = (denied < int'(SM)) ? denied + 1 : int'(SM);
        else                  denied = 0;
        pend       = (g0 && a.ren) || (g1 && b.ren);
        pend_owner = g1;
    endtask

    task automatic model_reset();
        denied = 0; pend = 1'b0; pend_owner = 1'b0;
    endtask

    task automatic apply(input rq_t a, input rq_t b, input logic [DW-1:0] rd);
        r0_ren = a.act ? a.ren : 1'b0;     r1_ren = b.act ? b.ren : 1'b0;
        r0_wen = a.act ? a.wen : '0;       r1_wen = b.act ? b.wen : '0;
        r0_raddr = a.act ? a.raddr : '0;   r1_raddr = b.act ? b.raddr : '0;
        r0_waddr = a.act ? a.waddr : '0;   r1_waddr = b.act ? b.waddr : '0;
        r0_wdata = a.act ? a.wdata : '0;   r1_wdata = b.act ? b.wdata : '0;
        m_rdata = rd;
    endtask

    task automatic drain();
        @(negedge clk); apply(no_rq(), no_rq(), DW'($urandom)); #1;
        model_step(no_rq(), no_rq());
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        apply(no_rq(), no_rq(), 32'hFFFF_FFFF); #1;
        n_checks++;
        if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid});
        end
        n_checks++;
        if (r0_rdata !== '0 || r1_rdata !== '0) begin
            n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", r0_rdata, r1_rdata);
        end
        n_checks++;
        if (m_bus !== '0) begin
            n_fail++; $display("FAIL reset_mbus: got %h want 0", m_bus);
        end
        @(negedge clk); apply(mk(1'b1, '0, 32'h40, '0, '0), no_rq(), 32'h1111_2222);
        @(negedge clk); #1;
        n_checks++;
        if (r0_gnt !== 1'b1 || r0_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_read_held: gnt=%b rvalid=%b want 1/0", r0_gnt, r0_rvalid);
        end
        apply(no_rq(), no_rq(), '0);
        reset = 1'b0;
        model_reset();
        drain();
    endtask

    task automatic test_single_read();
        rq_t a = mk(1'b1, '0, 32'h0000_0100, '0, '0);
        @(negedge clk); apply(a, no_rq(), DW'($urandom)); #1;
        n_checks++;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL single_gnt: got %b want 10", {r0_gnt, r1_gnt});
        end
        n_checks++;
        if (m_ren !== 1'b1 || m_raddr !== 32'h100 || m_wen !== '0) begin
            n_fail++; $display("FAIL single_fwd: got ren=%b raddr=%h wen=%h want 1/100/0", m_ren, m_raddr, m_wen);
        end
        model_step(a, no_rq());
        @(negedge clk); apply(no_rq(), no_rq(), 32'hDEAD_BEEF); #1;
        n_checks++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL single_rsp: got %b/%h want 1/deadbeef", r0_rvalid, r0_rdata);
        end
        n_checks++;
        if (r1_rvalid !== 1'b0 || r1_rdata !== '0) begin
            n_fail++; $display("FAIL single_other: got %b/%h want 0/0", r1_rvalid, r1_rdata);
        end
        model_step(no_rq(), no_rq());
        drain();
    endtask

    task automatic test_contention();
        rq_t a = mk(1'b1, '0, DW'($urandom), '0, '0);
        rq_t b = mk(1'b1, '0, DW'($urandom), '0, '0);
        bit prev0 = 1'b0;
        logic [DW-1:0] rd;
        for (int i = 0; i < 3 * int'(SM + 1); i++) begin
            bit exp0 = (i % int'(SM + 1)) == int'(SM);
            rd = $urandom;
            @(negedge clk); apply(a, b, rd); #1;
            n_checks++;
            if ({r0_gnt, r1_gnt} !== {exp0, !exp0}) begin
                n_fail++; $display("FAIL contention_gnt[%0d]: got %b want %b", i, {r0_gnt, r1_gnt}, {exp0, !exp0});
            end
            if (i > 0) begin
                n_checks++;
                if ({r0_rvalid, r1_rvalid} !== {prev0, !prev0} ||
                    (prev0 ? r0_rdata : r1_rdata) !== rd) begin
                    n_fail++; $display("FAIL contention_rsp[%0d]: got v=%b d0=%h d1=%h want owner0=%b data=%h",
                                       i, {r0_rvalid, r1_rvalid}, r0_rdata, r1_rdata, prev0, rd);
                end
            end
            model_step(a, b);
            prev0 = exp0;
            if (exp0) a.raddr = $urandom;
            else      b.raddr = $urandom;
        end
        drain();
    endtask

    task automatic test_pipelined_reads();
        rq_t b = mk(1'b1, '0, 32'h0000_A000, '0, '0);
        rq_t a = mk(1'b1, '0, 32'h0000_B000, '0, '0);
        logic [DW-1:0] x = $urandom;
        logic [DW-1:0] y = $urandom;
        @(negedge clk); apply(no_rq(), b, DW'($urandom)); #1;
        n_checks++;
        if ({r0_gnt, r1_gnt} !== 2'b01 || m_raddr !== 32'h0000_A000) begin
            n_fail++; $display("FAIL pipe_t0: gnt=%b raddr=%h want 01/a000", {r0_gnt, r1_gnt}, m_raddr);
        end
        model_step(no_rq(), b);
        @(negedge clk); apply(a, no_rq(), x); #1;
        n_checks++;
        if (r1_rvalid !== 1'b1 || r1_rdata !== x || r0_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL pipe_t1_rsp: r1=%b/%h r0v=%b want 1/%h/0", r1_rvalid, r1_rdata, r0_rvalid, x);
        end
        n_checks++;
        if ({r0_gnt, r1_gnt} !== 2'b10 || m_raddr !== 32'h0000_B000) begin
            n_fail++; $display("FAIL pipe_t1_gnt: gnt=%b raddr=%h want 10/b000", {r0_gnt, r1_gnt}, m_raddr);
        end
        model_step(a, no_rq());
        @(negedge clk); apply(no_rq(), no_rq(), y); #1;
        n_checks++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== y || r1_rvalid !== 1'b0 || r1_rdata !== '0) begin
            n_fail++; $display("FAIL pipe_t2_rsp: r0=%b/%h r1=%b/%h want 1/%h/0/0", r0_rvalid, r0_rdata, r1_rvalid, r1_rdata, y);
        end
        model_step(no_rq(), no_rq());
    endtask

    task automatic test_byte_write();
        rq_t b = mk(1'b0, 4'b0011, '0, 32'h0001_0004, 32'h1234_5678);
        @(negedge clk); apply(no_rq(), b, DW'($urandom)); #1;
        n_checks++;
        if ({r0_gnt, r1_gnt} !== 2'b01) begin
            n_fail++; $display("FAIL bytewr_gnt: got %b want 01", {r0_gnt, r1_gnt});
        end
        n_checks++;
        if (m_wen !== 4'b0011 || m_waddr !== 32'h0001_0004 || m_wdata !== 32'h1234_5678 || m_ren !== 1'b0) begin
            n_fail++; $display("FAIL bytewr_fwd: got wen=%b waddr=%h wdata=%h ren=%b", m_wen, m_waddr, m_wdata, m_ren);
        end
        model_step(no_rq(), b);
        @(negedge clk); apply(no_rq(), no_rq(), DW'($urandom)); #1;
        n_checks++;
        if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
            n_fail++; $display("FAIL bytewr_norsp: got %b want 00", {r0_rvalid, r1_rvalid});
        end
        model_step(no_rq(), no_rq());
    endtask

    task automatic test_mixed_access();
        rq_t a = mk(1'b0, 4'b1010, '0, 32'h0000_0C00, 32'hA5A5_5A5A);
        rq_t b = mk(1'b1, '0, 32'h0000_0D00, '0, '0);
        logic [DW-1:0] x = $urandom;
        @(negedge clk); apply(a, b, DW'($urandom)); #1;
        n_checks++;
        if ({r0_gnt, r1_gnt} !== 2'b01 || m_ren !== 1'b1 || m_wen !== '0) begin
            n_fail++; $display("FAIL mixed_c0: gnt=%b ren=%b wen=%b want 01/1/0", {r0_gnt, r1_gnt}, m_ren, m_wen);
        end
        model_step(a, b);
        @(negedge clk); apply(a, no_rq(), x); #1;
        n_checks++;
        if ({r0_gnt, r1_gnt} !== 2'b10 || m_wen !== 4'b1010 || m_waddr !== 32'h0000_0C00 || m_wdata !== 32'hA5A5_5A5A) begin
            n_fail++; $display("FAIL mixed_c1: gnt=%b wen=%b waddr=%h wdata=%h", {r0_gnt, r1_gnt}, m_wen, m_waddr, m_wdata);
        end
        n_checks++;
        if (r1_rvalid !== 1'b1 || r1_rdata !== x) begin
            n_fail++; $display("FAIL mixed_rsp: got %b/%h want 1/%h", r1_rvalid, r1_rdata, x);
        end
        model_step(a, no_rq());
        drain();
    endtask

    task automatic test_reset_mid_read();
        rq_t a = mk(1'b1, '0, 32'h0000_0200, '0, '0);
        rq_t c = mk(1'b1, '0, 32'h0000_0300, '0, '0);
        rq_t b = mk(1'b1, '0, 32'h0000_0400, '0, '0);
        @(negedge clk); apply(a, no_rq(), '0); #1;
        reset = 1'b1;
        model_reset();
        @(negedge clk); apply(no_rq(), no_rq(), 32'hCAFE_F00D); #1;
        n_checks++;
        if (r0_rvalid !== 1'b0 || r0_rdata !== '0) begin
            n_fail++; $display("FAIL rstmid_norsp: got %b/%h want 0/0", r0_rvalid, r0_rdata);
        end
        reset = 1'b0;
        drain();
        // Build the counter up to the force threshold, then reset with contention held.
        for (int i = 0; i < int'(SM); i++) begin
            @(negedge clk); apply(c, b, DW'($urandom)); #1;
            model_step(c, b);
        end
        @(negedge clk); apply(c, b, DW'($urandom)); #1;
        reset = 1'b1; #1; reset = 1'b0; #1;
        model_reset();
        n_checks++;
        if ({r0_gnt, r1_gnt} !== 2'b01) begin
            n_fail++; $display("FAIL rstmid_clean_cnt: got %b want 01", {r0_gnt, r1_gnt});
        end
        model_step(c, b);
        for (int i = 1; i <= int'(SM); i++) begin
            bit exp0 = (i == int'(SM));
            @(negedge clk); apply(c, b, DW'($urandom)); #1;
            n_checks++;
            if ({r0_gnt, r1_gnt} !== {exp0, !exp0}) begin
                n_fail++; $display("FAIL rstmid_after[%0d]: got %b want %b", i, {r0_gnt, r1_gnt}, {exp0, !exp0});
            end
            model_step(c, b);
        end
        drain();
    endtask

    task automatic test_random();
        rq_t q0 = no_rq();
        rq_t q1 = no_rq();
        logic [DW-1:0] rd;
        for (int i = 0; i < 400; i++) begin
            bit g0, g1, e0v, e1v;
            if (!q0.act && $urandom_range(0, 3) != 0) q0 = rand_rq();
            if (!q1.act && $urandom_range(0, 4) != 0) q1 = rand_rq();
            rd = $urandom;
            @(negedge clk); apply(q0, q1, rd); #1;
            g0  = model_g0(q0, q1);
            g1  = is_req(q1) && !g0;
            e0v = pend && !pend_owner;
            e1v = pend && pend_owner;
            n_checks++;
            if ({r0_gnt, r1_gnt} !== {g0, g1}) begin
                n_fail++; $display("FAIL rand_gnt[%0d]: got %b want %b", i, {r0_gnt, r1_gnt}, {g0, g1});
            end
            n_checks++;
            if (m_bus !== model_m(q0, q1)) begin
                n_fail++; $display("FAIL rand_mbus[%0d]: got %h want %h", i, m_bus, model_m(q0, q1));
            end
            n_checks++;
            if ({r0_rvalid, r1_rvalid} !== {e0v, e1v}) begin
                n_fail++; $display("FAIL rand_rvalid[%0d]: got %b want %b", i, {r0_rvalid, r1_rvalid}, {e0v, e1v});
            end
            n_checks++;
            if (r0_rdata !== (e0v ? rd : '0) || r1_rdata !== (e1v ? rd : '0)) begin
                n_fail++; $display("FAIL rand_rdata[%0d]: got %h/%h want %h/%h", i, r0_rdata, r1_rdata,
                                   e0v ? rd : '0, e1v ? rd : '0);
            end
            model_step(q0, q1);
            if (g0) q0.act = 1'b0;
            if (g1) q1.act = 1'b0;
        end
        drain();
    endtask

    initial begin
        reset = 1'b1;
        apply(no_rq(), no_rq(), '0);
        test_reset();
        test_single_read();
        test_contention();
        test_pipelined_reads();
        test_byte_write();
        test_mixed_access();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
